// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: next-PC opcode encodings and default vectors for the fetch sequencer.
package pc_sequencer_pkg;
    localparam int NPCOp_len = 2;
    localparam logic [NPCOp_len-1:0] NPC_PC4 = 2'd0;
    localparam logic [NPCOp_len-1:0] NPC_B   = 2'd1;
    localparam logic [NPCOp_len-1:0] NPC_J   = 2'd2;
    localparam logic [NPCOp_len-1:0] NPC_JR  = 2'd3;
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] DEF_EX_VECTOR = 32'h0000_4180;
endpackage

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular return-address stack; overflow overwrites the oldest entry, empty pops are ignored.
module return_addr_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         valid
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_ptr;
    logic [AW:0]   r_cnt;
    logic          w_full;
    logic [AW-1:0] w_widx;
    assign valid  = r_cnt != '0;
    assign top    = valid ? r_mem[r_ptr] : '0;
    assign w_full = r_cnt == (AW+1)'(DEPTH);
    // A simultaneous push/pop replaces the top in place instead of moving the pointer.
    assign w_widx = pop ? r_ptr : r_ptr + AW'(1);
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (push && pop) begin
            if (!valid) r_cnt <= (AW+1)'(1);
        end else if (push) begin
            r_ptr <= w_widx;
            if (!w_full) r_cnt <= r_cnt + (AW+1)'(1);
        end else if (pop && valid) begin
            r_ptr <= r_ptr - AW'(1);
            r_cnt <= r_cnt - (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (!reset && push) r_mem[w_widx] <= din;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered fetch PC with exception/eret redirect, stall hold and a RAS-checked jr $31 predictor.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EX_VECTOR  = DEF_EX_VECTOR,
    parameter int          DELAY_SLOT = 1,
    parameter int          RAS_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic [NPCOp_len-1:0] NPCOp,
    input  logic                 ben,
    input  logic [25:0]          imm26,
    input  logic [31:0]          pcD,
    input  logic [31:0]          ra,
    input  logic                 call,
    input  logic                 ret,
    input  logic                 kernel,
    input  logic                 eret,
    input  logic [31:0]          epc,
    output logic [31:0]          pc,
    output logic [31:0]          pc8,
    output logic                 pc_misaligned,
    output logic [31:0]          ras_top,
    output logic                 ras_valid,
    output logic [31:0]          jr_count,
    output logic [31:0]          jr_mispred
);
    localparam logic [31:0] LINK = (DELAY_SLOT != 0) ? 32'd8 : 32'd4;
    logic [31:0] r_pc, r_jr_count, r_jr_mispred;
    logic [31:0] w_pc4, w_pcd4, w_br, w_j, w_npc;
    logic        w_en, w_miss;
    assign w_pc4  = r_pc + 32'd4;
    assign w_pcd4 = pcD + 32'd4;
    assign w_br   = w_pcd4 + {{14{imm26[15]}}, imm26[15:0], 2'b00};
    assign w_j    = {w_pcd4[31:28], imm26, 2'b00};
    always_comb begin
        w_npc = kernel ? EX_VECTOR :
                eret   ? epc :
                stall  ? r_pc :
                (NPCOp == NPC_B)  ? (ben ? w_br : w_pc4) :
                (NPCOp == NPC_J)  ? w_j :
                (NPCOp == NPC_JR) ? ra : w_pc4;
    end
    assign w_en   = !stall && !kernel && !eret;
    assign w_miss = !ras_valid || (ra != ras_top);
    return_addr_stack #(.DEPTH(RAS_DEPTH), .W(32)) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (w_en && call),
        .pop   (w_en && ret),
        .din   (pcD + LINK),
        .top   (ras_top),
        .valid (ras_valid)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_jr_count   <= '0;
            r_jr_mispred <= '0;
        end else begin
            r_pc <= w_npc;
            if (w_en && ret) begin
                if (r_jr_count != '1) r_jr_count <= r_jr_count + 32'd1;
                if (w_miss && r_jr_mispred != '1) r_jr_mispred <= r_jr_mispred + 32'd1;
            end
        end
    end
    assign pc            = r_pc;
    assign pc8           = r_pc + LINK;
    assign pc_misaligned = r_pc[1:0] != 2'b00;
    assign jr_count      = r_jr_count;
    assign jr_mispred    = r_jr_mispred;
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Registered program-counter sequencer for the fetch stage. It generalises the combinational next-PC logic with:
- the PC register itself, with stall hold;
- reset and exception vectors set by parameters;
- delay-slot mode set by a parameter;
- a parametrised return-address stack (RAS) that checks every `jr $31` against the predicted return address and counts mispredictions.

It sits between the decode stage (branch/jump resolution) and the instruction memory address port.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset.
- `EX_VECTOR`, 32'h0000_4180, exception entry address.
- `DELAY_SLOT`, 1, when 1 the link/return address is +8, when 0 it is +4.
- `RAS_DEPTH`, 4, number of RAS entries; must be a power of 2 and ≥2.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hold the PC and freeze RAS updates.
- `NPCOp` in `NPCOp_len`: `NPC_PC4` / `NPC_B` / `NPC_J` / `NPC_JR`, qualifying the instruction in D.
- `ben` in 1: branch condition is true.
- `imm26` in 26: immediate field of the D instruction.
- `pcD` in 32: PC of the D instruction.
- `ra` in 32: resolved, forwarded register value for JR.
- `call` in 1: D holds `jal`/`jalr`; push onto the RAS.
- `ret` in 1: D holds `jr $31`; pop from the RAS.
- `kernel` in 1: exception taken.
- `eret` in 1: return from exception.
- `epc` in 32: exception return address.
- `pc` out 32: current fetch PC (registered).
- `pc8` out 32: `pc` + (`DELAY_SLOT` ? 8 : 4).
- `pc_misaligned` out 1: `pc[1:0] != 0`.
- `ras_top` out 32: top RAS entry, or 0 when the stack is empty.
- `ras_valid` out 1: RAS holds at least one entry.
- `jr_count` out 32: `ret` events retired.
- `jr_mispred` out 32: `ret` events whose `ra` ≠ predicted value, or that popped an empty stack.

## Operation
- **Reset.** `pc` = `RESET_PC`. RAS count and pointer = 0. Both counters = 0.

- **Next-PC priority** (highest first), evaluated every cycle:
  1. `kernel` → `EX_VECTOR`; ignores `stall`.
  2. `eret` → `epc`; ignores `stall`.
  3. `stall` → hold `pc`.
  4. Otherwise by `NPCOp`:
     - `NPC_PC4`: `pc`+4.
     - `NPC_B`: if `ben`, `pcD`+4+(sext(`imm26[15:0]`)<<2); else `pc`+4.
     - `NPC_J`: {(`pcD`+4)[31:28], `imm26`, 2'b00}.
     - `NPC_JR`: `ra`.
- **Arithmetic.** All adds are 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- **RAS gating.** The RAS updates only when `stall`=0, `kernel`=0 and `eret`=0.
- **Push** (`call`): write `pcD`+(`DELAY_SLOT` ? 8 : 4) at the new top.
  - The stack is circular.
  - When full, the push overwrites the oldest entry and the count stays at `RAS_DEPTH`.
- **Pop** (`ret`):
  - Compare `ra` with `ras_top`.
  - Increment `jr_count`.
  - Increment `jr_mispred` if they differ or if the stack is empty.
  - If non-empty, decrement the count and move the pointer.
  - Popping an empty stack leaves the pointer unchanged.
- **`call` and `ret` in the same cycle:**
  - Count the pop as above.
  - Overwrite the top entry with the push value. The count is unchanged, or becomes 1 if the stack was empty.
- **Counters** saturate at 32'hFFFF_FFFF.

## Timing
- `pc` updates on the `clk` edge following the inputs; fetch-to-next-fetch latency is 1 cycle.
- `pc8`, `pc_misaligned`, `ras_top` and `ras_valid` are combinational from registered state.
- A RAS push is visible on `ras_top` the cycle after the push.
- Counters update on the edge at the end of the `ret` cycle.
- `reset` dominates all inputs, including `kernel`. A reset mid-stall or mid-redirect discards all pending state.
- `stall` and `kernel` together → PC = `EX_VECTOR`, RAS frozen.
- `kernel` and `eret` together → `kernel` wins.

## Structure
- `def.v` holds:
  - `NPCOp_len` (2);
  - `NPC_PC4`=0, `NPC_B`=1, `NPC_J`=2, `NPC_JR`=3;
  - default `RESET_PC` and `EX_VECTOR` values.
- One sub-module, `return_addr_stack`:
  - parameters `DEPTH` and `W`=32;
  - ports `push`, `pop`, `din`, `top`, `valid`, with the circular-overwrite and empty-pop rules above.
- The next-PC mux, the PC register and the counters live in `pc_sequencer`.

## Test plan
- **Reset, then sequential fetch.** Assert `reset` for 1 cycle, then `NPCOp`=`NPC_PC4` for 3 cycles → `pc` = 3000, 3004, 3008, 300C. `pc8` = 3008 when `pc`=3000 and `DELAY_SLOT`=1.
- **Branch and jump.**
  - `pcD`=3010, `imm26[15:0]`=16'hFFFC, `ben`=1 → next `pc`=3004.
  - Same with `ben`=0 → `pc`+4.
  - `NPC_J`, `imm26`=26'h0000C40, `pcD`=3010 → 0000_3100.
- **Stall against exception.**
  - `stall`=1 for 2 cycles → `pc` held.
  - `stall`=1 with `kernel`=1 → `pc`=4180 and RAS unchanged.
  - Next cycle `eret`=1, `epc`=3020 → `pc`=3020.
- **RAS hit and miss.**
  - `call` at `pcD`=3000, then `ret` with `ra`=3008 → `jr_count`=1, `jr_mispred`=0, `ras_valid`=0.
  - A further `ret` with `ra`=3008 → `jr_mispred`=1.
- **RAS overflow.** Apply `RAS_DEPTH`+1=5 calls at `pcD`=3000, 3010, 3020, 3030, 3040, then 5 rets with the matching `ra` values, newest first → first 4 hit, the 5th mispredicts because its entry was overwritten. Final `jr_mispred`=1.
- **Push and pop together, wrap-around, and reset mid-run.**
  - Simultaneous `call` and `ret` on an empty stack → `ras_valid`=1, `jr_mispred`+1.
  - `pc` at FFFF_FFFC with `NPC_PC4` → 0.
  - `reset` mid-run → counters=0 and `ras_valid`=0.
